// File: rtl/dummy_if_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
// dummy_if_pkg : shared state encoding, line levels and parity helper for the
//                dummy_if serial transmitter.                    Rev 1.0
// ============================================================================
package dummy_if_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Even parity over the low w bits of d.
  function automatic logic par_even(input logic [31:0] d, input int w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dummy_if_serial_tx_if.sv
`default_nettype none
// ============================================================================
// dummy_if : single-bit serial link; slave drives the line, master reads it.
//                                                                 Rev 1.0
// ============================================================================
interface dummy_if;
  logic signal;

  modport master (input  signal);
  modport slave  (output signal);
endinterface
`default_nettype wire

// File: rtl/dummy_if_serial_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// dummy_if_bit_timer : bit-period counter, tick on last clock of each period.
//                                                                 Rev 1.0
// ============================================================================
module dummy_if_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] c_last = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (rst || clr || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dummy_if_serial_tx.sv
`default_nettype none
// ============================================================================
// dummy_if_serial_tx : start / LSB-first data / [parity] / stop serialiser.
// Optional parity bit: define DUMMY_IF_SERIAL_TX_PARITY_EN.       Rev 1.0
// ============================================================================
module dummy_if_serial_tx
  import dummy_if_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  dummy_if.slave            tx_if
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] c_last_idx = IW'(DATA_W - 1);
  localparam logic [IW-1:0] c_idx_one  = IW'(1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [IW-1:0]     r_idx;
  logic              r_signal;
  logic              r_busy;
  logic              w_tick;
  logic              w_fire;
  logic [DATA_W-1:0] w_shreg_next;
  tx_state_t         w_after_data;
  logic              w_after_data_lvl;

`ifdef DUMMY_IF_SERIAL_TX_PARITY_EN
  logic r_par;
  assign w_after_data     = PARITY;
  assign w_after_data_lvl = r_par;
`else
  assign w_after_data     = STOP;
  assign w_after_data_lvl = STOP_LVL;
`endif

  assign in_ready     = (r_state == IDLE) && !rst;
  assign w_fire       = in_valid && in_ready;
  assign w_shreg_next = r_shreg >> 1;
  assign busy         = r_busy;
  assign tx_if.signal = r_signal;

  // Timer is held clear in IDLE so the start bit always gets a full period.
  dummy_if_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state == IDLE),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_idx    <= '0;
      r_signal <= LINE_IDLE;
      r_busy   <= 1'b0;
`ifdef DUMMY_IF_SERIAL_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_shreg  <= in_data;
            r_idx    <= '0;
            r_state  <= START;
            r_signal <= START_LVL;
            r_busy   <= 1'b1;
`ifdef DUMMY_IF_SERIAL_TX_PARITY_EN
            r_par    <= par_even(32'(in_data), DATA_W);
`endif
          end
        end
        START: begin
          if (w_tick) begin
            r_state  <= DATA;
            r_signal <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == c_last_idx) begin
              r_idx    <= '0;
              r_state  <= w_after_data;
              r_signal <= w_after_data_lvl;
            end else begin
              r_idx    <= r_idx + c_idx_one;
              r_shreg  <= w_shreg_next;
              r_signal <= w_shreg_next[0];
            end
          end
        end
`ifdef DUMMY_IF_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_state  <= STOP;
            r_signal <= STOP_LVL;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_state  <= IDLE;
            r_signal <= LINE_IDLE;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_signal <= LINE_IDLE;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dummy_if_serial_tx.sv
`default_nettype none
// ============================================================================
// tb_dummy_if_serial_tx : scoreboard bench for two transmitter configurations.
//                                                                 Rev 1.0
// ============================================================================
module tb_dummy_if_serial_tx;

  localparam int BC0 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [7:0] d0;
  logic [0:0] d1;
  logic       rdy0, rdy1, busy0, busy1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic q0[$];
  logic q1[$];

  dummy_if tx0 ();
  dummy_if tx1 ();

  dummy_if_serial_tx #(.DATA_W(8), .BIT_CYCLES(BC0)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v0),
    .in_ready (rdy0),
    .in_data  (d0),
    .busy     (busy0),
    .tx_if    (tx0)
  );

  dummy_if_serial_tx #(.DATA_W(1), .BIT_CYCLES(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (v1),
    .in_ready (rdy1),
    .in_data  (d1),
    .busy     (busy1),
    .tx_if    (tx1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Expected per-clock line levels of one frame.
  task automatic push0(input logic [7:0] d);
    for (int k = 0; k < BC0; k++) q0.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < BC0; k++) q0.push_back(d[i]);
`ifdef DUMMY_IF_SERIAL_TX_PARITY_EN
    for (int k = 0; k < BC0; k++) q0.push_back(^d);
`endif
    for (int k = 0; k < BC0; k++) q0.push_back(1'b1);
  endtask

  task automatic push1(input logic d);
    q1.push_back(1'b0);
    q1.push_back(d);
`ifdef DUMMY_IF_SERIAL_TX_PARITY_EN
    q1.push_back(d);
`endif
    q1.push_back(1'b1);
  endtask

  task automatic send0(input logic [7:0] d, input bit hold);
    int n;
    n  = 0;
    v0 = 1'b1;
    d0 = d;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy0 && n < 200);
    if (!rdy0) begin
      fail_now("send0_ready");
      v0 = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push0(d);
      if (!hold) v0 = 1'b0;
    end
  endtask

  task automatic send1(input logic d, input bit hold);
    int n;
    n  = 0;
    v1 = 1'b1;
    d1 = d;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy1 && n < 200);
    if (!rdy1) begin
      fail_now("send1_ready");
      v1 = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push1(d);
      if (!hold) v1 = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // Monitors: a queued level means a frame cycle, an empty queue means idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q0.size() > 0) begin
        logic e0;
        e0 = q0.pop_front();
        chk("line0", tx0.signal, e0);
        chk("busy0", busy0, 1'b1);
        chk("ready0", rdy0, 1'b0);
      end else begin
        chk("idle0", tx0.signal, 1'b1);
        chk("busy0_idle", busy0, 1'b0);
        chk("ready0_idle", rdy0, !rst);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (q1.size() > 0) begin
        logic e1;
        e1 = q1.pop_front();
        chk("line1", tx1.signal, e1);
        chk("busy1", busy1, 1'b1);
        chk("ready1", rdy1, 1'b0);
      end else begin
        chk("idle1", tx1.signal, 1'b1);
        chk("busy1_idle", busy1, 1'b0);
        chk("ready1_idle", rdy1, !rst);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v0  = 1'b1;
    v1  = 1'b1;
    d0  = 8'hFF;
    d1  = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    v0  = 1'b0;
    v1  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    send0(8'hA5, 1'b0);
    drain();

    send0(8'h01, 1'b1);
    send0(8'h80, 1'b0);
    drain();

    send0(8'h07, 1'b0);
    send0(8'h03, 1'b0);
    drain();

    // Abort a frame of 8'h00 during data bit 3.
    send0(8'h00, 1'b0);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 q0.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    send1(1'b1, 1'b0);
    drain();
    send1(1'b0, 1'b1);
    send1(1'b1, 1'b0);
    drain();

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dummy_if_serial_tx.md
Name: dummy_if_serial_tx

Overview:
- Transmit end of the single-bit `dummy_if` link. Drives `signal` only through the `slave` modport, whose direction is `output signal`.
- Accepts a parallel word on a valid/ready handshake and serialises it as a frame: start bit, data bits LSB-first, optional parity bit, stop bit.
- Each bit is held for BIT_CYCLES clocks.
- Pairs with a receiver that reads `signal` through the `master` modport, whose direction is `input signal`.

Parameters:
- DATA_W, 8: data bits per frame; legal range 1..32.
- BIT_CYCLES, 4: clocks per serial bit; must be >= 1.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  word to send.
- busy  output  1  frame in progress.
- tx_if  modport dummy_if.slave  1  the only driver of tx_if.signal.

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE; tx_if.signal = 1; busy = 0.
  - in_ready = 0 during every cycle rst is high, and = 1 from the first cycle after deassertion.
  - No word is accepted while rst is high.
- Idle line level: tx_if.signal = 1.
- Handshake:
  - Transfer occurs at the edge where in_valid && in_ready.
  - in_ready = (state == IDLE) && !rst.
  - in_data is captured into a shift register at that edge.
  - in_valid/in_data are ignored outside IDLE; there is no buffering.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE -> START on transfer. The start bit appears on signal in the cycle after the transfer edge.
  - START: signal = 0 for BIT_CYCLES clocks, then go to DATA.
  - DATA: signal = shreg[0]. Shift right once every BIT_CYCLES clocks. After DATA_W bits go to PARITY if compiled in, else to STOP.
  - STOP: signal = 1 for BIT_CYCLES clocks, then go to IDLE.
- Outputs: signal and busy are registered outputs. busy = 1 in every state except IDLE.
- Bit counter:
  - Counts 0..BIT_CYCLES-1; width max(1, $clog2(BIT_CYCLES)).
  - It is reset on every state change.
  - BIT_CYCLES = 1 means one clock per bit; no special case in the logic.
- Data index: counts 0..DATA_W-1; width max(1, $clog2(DATA_W)); wraps to 0 on leaving DATA.
- Frame length: (DATA_W + 2 [+1 with parity]) * BIT_CYCLES clocks from the first start cycle to the last stop cycle.
- Back-to-back:
  - in_ready rises in the first cycle after the last stop cycle.
  - Minimum inter-frame gap is exactly 1 idle-high clock.
- Reset mid-frame:
  - The frame is aborted immediately.
  - signal = 1 in the cycle after the reset edge.
  - No partial-frame resume.

Optional Feature:
- Macro: DUMMY_IF_SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - signal = even parity = XOR of all DATA_W bits of the captured word, held for BIT_CYCLES clocks.
  - Frame length becomes (DATA_W + 3) * BIT_CYCLES.
  - Parity is computed at capture time, not from the shifting register.
- Undefined: the PARITY state and parity register are absent; DATA goes directly to STOP.

Decomposition:
- Package dummy_if_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam LINE_IDLE = 1'b1, START_LVL = 1'b0, STOP_LVL = 1'b1.
  - Function par_even(input logic [31:0] d, input int w).
- One natural sub-module, dummy_if_bit_timer:
  - Parameter BIT_CYCLES.
  - Inputs clk, rst, clr. Output tick, which pulses on the last cycle of each bit period.
  - The FSM advances only on tick.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 → signal=1, busy=0, in_ready=0, no capture. After release, in_ready=1 on the next cycle.
- Single frame, DATA_W=8, BIT_CYCLES=4, in_data=8'hA5 → starting the cycle after transfer, line shows 0 then bits 1,0,1,0,0,1,0,1 then 1. Each bit lasts 4 clocks; frame is 40 clocks; busy high for exactly 40 clocks.
- Back-to-back, in_valid held high with 8'h01 then 8'h80 → second start bit begins exactly 1 idle clock after the first stop bit ends. The second word is not sampled during the first frame.
- BIT_CYCLES=1, DATA_W=1, in_data=1 → line sequence 0,1,1 over 3 clocks, then idle.
- Mid-frame reset: assert rst during data bit 3 of 8'h00 → signal=1 the next cycle; after release, line idle and in_ready=1; no residual bits appear.
- PARITY_EN defined, in_data=8'h07 → parity bit 1; in_data=8'h03 → parity bit 0. Frame is 44 clocks at BIT_CYCLES=4.
